// File: rtl/anaio_sw_seq.sv
// anaio_sw_seq: break-before-make sequencer for the analog pad switch matrix (clk/rst, req_* handshake in; sw_en/dis_en/busy/conn/conn_ch/err out)
module anaio_sw_seq #(
  parameter int NCH = 4,
  parameter int BREAK_CYC = 8,
  parameter int SETTLE_CYC = 32,
  parameter int CW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_ch,
  input  logic           req_off,
  output logic [NCH-1:0] sw_en,
  output logic           dis_en,
  output logic           busy,
  output logic           conn,
  output logic [2:0]     conn_ch,
  output logic           err
);
  typedef enum logic [1:0] {IDLE, BRK, SETTLE, CONN} state_t;
  localparam logic [CW-1:0] BRK_LD = CW'(BREAK_CYC - 1);
  localparam logic [CW-1:0] STL_LD = CW'(SETTLE_CYC - 1);
  localparam logic [3:0] NCH4 = 4'(NCH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] tgt;
  logic tgt_off, accept, bad;
  assign req_ready = state == IDLE || state == CONN;
  assign accept = req_valid && req_ready;
  assign bad = !req_off && {1'b0, req_ch} >= NCH4;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tgt <= '0;
      tgt_off <= 1'b0;
      sw_en <= '0;
      dis_en <= 1'b0;
      busy <= 1'b0;
      conn <= 1'b0;
      conn_ch <= '0;
      err <= 1'b0;
    end else if (accept) begin
      state <= BRK;
      cnt <= BRK_LD;
      tgt <= req_ch;
      tgt_off <= req_off || bad;
      err <= err || bad;
      sw_en <= '0;
      dis_en <= 1'b1;
      busy <= 1'b1;
      conn <= 1'b0;
    end else begin
      unique case (state)
        BRK: begin
          if (cnt == '0) begin
            state <= tgt_off ? IDLE : SETTLE;
            cnt <= tgt_off ? '0 : STL_LD;
            sw_en <= tgt_off ? '0 : NCH'(1) << tgt;
            dis_en <= 1'b0;
            busy <= !tgt_off;
          end else cnt <= cnt - 1'b1;
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= CONN;
            conn <= 1'b1;
            conn_ch <= tgt;
            busy <= 1'b0;
          end else cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
